// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg : shared FIFO pointer-width helper and read-mode constants (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

package fifo_pkg;

  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;

  // Pointer and count width: address bits plus one wrap bit.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sync_fifo_param_if.sv
// ---------------------------------------------------------------------------
// sync_fifo_param_if : producer/consumer handshake bundle for sync_fifo_param (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  import fifo_pkg::*;

  localparam int CNT_W = ptr_width(DEPTH);

  logic              winc;
  logic [DATA_W-1:0] wdata;
  logic              rinc;
  logic [DATA_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output winc, wdata, rinc,
    input  rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  winc, wdata, rinc,
    output rdata, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

`default_nettype wire

// File: rtl/fifo_mem_sdp.sv
// ---------------------------------------------------------------------------
// fifo_mem_sdp : DATA_W x DEPTH array, synchronous write, asynchronous read (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module fifo_mem_sdp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
) (
  input  wire logic                     clk,
  input  wire logic                     we,
  input  wire logic [$clog2(DEPTH)-1:0] waddr,
  input  wire logic [DATA_W-1:0]        wdata,
  input  wire logic [$clog2(DEPTH)-1:0] raddr,
  output logic      [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/sync_fifo_param.sv
// ---------------------------------------------------------------------------
// sync_fifo_param : single-clock FIFO with thresholds, error pulses, FWFT mode (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = DEPTH - 2,
  parameter int AE_LEVEL = 2,
  parameter int FWFT     = MODE_STD
) (
  input wire logic          clk,
  input wire logic          rst_n,
  sync_fifo_param_if.slave  bus
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = ptr_width(DEPTH);

  localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AF_LEVEL);
  localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AE_LEVEL);

  logic [CNT_W-1:0]  r_wptr, r_rptr, r_count;
  logic [CNT_W-1:0]  w_wptr_nxt, w_rptr_nxt, w_count_nxt;
  logic              r_full, r_empty, r_af, r_ae, r_ovf, r_udf;
  logic              w_wr_acc, w_rd_acc;
  logic [DATA_W-1:0] w_head;

  assign w_wr_acc = bus.winc & ~r_full;
  assign w_rd_acc = bus.rinc & ~r_empty;

  // Pointers wrap modulo 2*DEPTH, so their difference is the exact occupancy.
  assign w_wptr_nxt  = r_wptr + CNT_W'(w_wr_acc);
  assign w_rptr_nxt  = r_rptr + CNT_W'(w_rd_acc);
  assign w_count_nxt = w_wptr_nxt - w_rptr_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
      r_af    <= 1'b0;
      r_ae    <= 1'b1;
      r_ovf   <= 1'b0;
      r_udf   <= 1'b0;
    end else begin
      r_wptr  <= w_wptr_nxt;
      r_rptr  <= w_rptr_nxt;
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
      r_af    <= (w_count_nxt >= C_AF);
      r_ae    <= (w_count_nxt <= C_AE);
      r_ovf   <= bus.winc & r_full;
      r_udf   <= bus.rinc & r_empty;
    end
  end

  fifo_mem_sdp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (clk),
    .we    (w_wr_acc),
    .waddr (r_wptr[AW-1:0]),
    .wdata (bus.wdata),
    .raddr (r_rptr[AW-1:0]),
    .rdata (w_head)
  );

  generate
    if (FWFT == MODE_FWFT) begin : g_fwft
      assign bus.rdata = w_head;
    end else begin : g_std
      logic [DATA_W-1:0] r_rdata;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rdata <= '0;
        end else if (w_rd_acc) begin
          r_rdata <= w_head;
        end
      end
      assign bus.rdata = r_rdata;
    end
  endgenerate

  assign bus.full         = r_full;
  assign bus.empty        = r_empty;
  assign bus.almost_full  = r_af;
  assign bus.almost_empty = r_ae;
  assign bus.count        = r_count;
  assign bus.overflow     = r_ovf;
  assign bus.underflow    = r_udf;

endmodule

`default_nettype wire

// File: tb/tb_sync_fifo_param.sv
// ---------------------------------------------------------------------------
// tb_sync_fifo_param : queue-model scoreboard bench for standard and FWFT FIFOs (rev 1.0)
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sync_fifo_param;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_LVL = 14;
  localparam int AE_LVL = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic winc = 1'b0;
  logic rinc = 1'b0;
  logic [DATA_W-1:0] wdata = '0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if0 ();
  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) if1 ();

  assign if0.winc = winc;
  assign if0.wdata = wdata;
  assign if0.rinc = rinc;
  assign if1.winc = winc;
  assign if1.wdata = wdata;
  assign if1.rinc = rinc;

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LVL), .AE_LEVEL(AE_LVL), .FWFT(0))
    u_std (.clk(clk), .rst_n(rst_n), .bus(if0));

  sync_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_LEVEL(AF_LVL), .AE_LEVEL(AE_LVL), .FWFT(1))
    u_fwft (.clk(clk), .rst_n(rst_n), .bus(if1));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of stored words.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] exp_q[$];
  int                exp_count = 0;
  bit                exp_ovf = 1'b0;
  bit                exp_udf = 1'b0;
  logic [DATA_W-1:0] last_rd = '0;
  logic [DATA_W-1:0] exp_head = '0;

  always @(posedge clk or negedge rst_n) begin : model
    bit wa, ra;
    if (!rst_n) begin
      mq.delete();
      exp_q.delete();
      exp_count = 0;
      exp_ovf = 1'b0;
      exp_udf = 1'b0;
      last_rd = '0;
    end else begin
      wa = winc && (mq.size() < DEPTH);
      ra = rinc && (mq.size() > 0);
      if (ra) begin
        last_rd = mq.pop_front();
        exp_q.push_back(last_rd);
      end
      if (wa) mq.push_back(wdata);
      exp_ovf = winc && !wa;
      exp_udf = rinc && !ra;
      exp_count = mq.size();
      if (mq.size() > 0) exp_head = mq[0];
    end
  end

  always @(negedge clk) begin : monitor
    if (rst_n) begin
      check("count", 32'(if0.count), exp_count);
      check("empty", 32'(if0.empty), 32'(exp_count == 0));
      check("full", 32'(if0.full), 32'(exp_count == DEPTH));
      check("almost_full", 32'(if0.almost_full), 32'(exp_count >= AF_LVL));
      check("almost_empty", 32'(if0.almost_empty), 32'(exp_count <= AE_LVL));
      check("overflow", 32'(if0.overflow), 32'(exp_ovf));
      check("underflow", 32'(if0.underflow), 32'(exp_udf));
      if (exp_q.size() > 0) check("rdata_std", 32'(if0.rdata), 32'(exp_q.pop_front()));
      else check("rdata_hold", 32'(if0.rdata), 32'(last_rd));
      check("count_fwft", 32'(if1.count), exp_count);
      check("underflow_fwft", 32'(if1.underflow), 32'(exp_udf));
      check("overflow_fwft", 32'(if1.overflow), 32'(exp_ovf));
      if (exp_count > 0) check("rdata_fwft", 32'(if1.rdata), 32'(exp_head));
    end
  end

  task automatic drive(input bit w, input logic [DATA_W-1:0] d, input bit r);
    @(negedge clk);
    winc = w;
    wdata = d;
    rinc = r;
  endtask

  task automatic idle();
    drive(1'b0, '0, 1'b0);
    #1;
  endtask

  task automatic reset_checks();
    check("rst_count", 32'(if0.count), 0);
    check("rst_empty", 32'(if0.empty), 1);
    check("rst_almost_empty", 32'(if0.almost_empty), 1);
    check("rst_full", 32'(if0.full), 0);
    check("rst_almost_full", 32'(if0.almost_full), 0);
    check("rst_overflow", 32'(if0.overflow), 0);
    check("rst_underflow", 32'(if0.underflow), 0);
    check("rst_rdata", 32'(if0.rdata), 0);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    winc = 1'b0;
    rinc = 1'b0;
    #1 rst_n = 1'b0;
    #1 reset_checks();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    #11 reset_checks();
    rst_n = 1'b1;

    // Reset in the middle of traffic, then a read must underflow
    for (int i = 0; i < 5; i++) drive(1'b1, 8'(8'hC0 + i), 1'b0);
    pulse_reset();
    drive(1'b0, '0, 1'b1);
    idle();
    check("post_rst_underflow", 32'(if0.underflow), 1);

    // Fill with 0x01..0x10
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      idle();
      check("fill_almost_empty", 32'(if0.almost_empty), 32'(i <= AE_LVL));
      check("fill_almost_full", 32'(if0.almost_full), 32'(i >= AF_LVL));
    end
    check("fill_full", 32'(if0.full), 1);
    check("fill_count", 32'(if0.count), 16);
    drive(1'b1, 8'hFF, 1'b0);
    idle();
    check("overflow_pulse", 32'(if0.overflow), 1);
    check("overflow_count", 32'(if0.count), 16);
    idle();
    check("overflow_single", 32'(if0.overflow), 0);

    // Drain in order
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1'b0, '0, 1'b1);
      idle();
      check("drain_data", 32'(if0.rdata), 32'(i));
    end
    check("drain_empty", 32'(if0.empty), 1);
    drive(1'b0, '0, 1'b1);
    idle();
    check("drain_underflow", 32'(if0.underflow), 1);
    check("drain_hold", 32'(if0.rdata), 32'h10);

    // Sustained concurrent traffic through many wraps at count=8
    pulse_reset();
    for (int i = 0; i < 8; i++) drive(1'b1, 8'($urandom), 1'b0);
    for (int i = 0; i < 300; i++) drive(1'b1, 8'($urandom), 1'b1);
    idle();
    check("wrap_count", 32'(if0.count), 8);

    // Simultaneous read+write while full
    pulse_reset();
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b1, 8'hEE, 1'b1);
    idle();
    check("full_rw_overflow", 32'(if0.overflow), 1);
    check("full_rw_count", 32'(if0.count), 15);

    // Simultaneous read+write while empty
    pulse_reset();
    drive(1'b1, 8'h33, 1'b1);
    idle();
    check("empty_rw_underflow", 32'(if0.underflow), 1);
    check("empty_rw_count", 32'(if0.count), 1);

    // First-word-fall-through visibility
    pulse_reset();
    drive(1'b1, 8'hA5, 1'b0);
    idle();
    check("fwft_first", 32'(if1.rdata), 32'hA5);
    drive(1'b1, 8'h5A, 1'b0);
    drive(1'b0, '0, 1'b1);
    idle();
    check("fwft_next", 32'(if1.rdata), 32'h5A);
    check("fwft_count", 32'(if1.count), 1);

    // Random mixed traffic
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 4; i++) idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
